ctrl_lut_seq: RTL and testbench
===============================

# ctrl_lut_seq

Parametrised, registered successor to the combinational control LUT in the SNACKS processor. It translates `{mode, opcode, zero flag}` into a control word through a runtime-writable control store and owns the zero-flag register. It holds LD/ST control words for a configurable memory latency and applies back-pressure to the fetch stage while it does so. It sits between instruction fetch and the datapath; reset restores the legacy control table.

## Interface

Parameters:
- `OPW`, 4: opcode width. The control store depth is `2^(OPW+2)` entries, addressed by `{mode, op, flag}`.
- `CW`, 6: control-word width, `CW >= 6`. The default table fills bits [5:0]; upper bits reset to 0.
- `MEM_LAT`, 1: extra hold cycles for LD/ST, 0–15.
- `LD_OP`, 5: opcode of LD.
- `ST_OP`, 6: opcode of ST.

Ports:
- `CLK` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: an instruction is presented.
- `in_ready` output 1: the block can accept an instruction this cycle.
- `in_mode` input 1: instruction mode bit, address MSB.
- `in_op` input OPW: opcode.
- `flag_we` input 1: load the zero flag from `alu_zero`.
- `alu_zero` input 1: zero result from the ALU.
- `cfg_we` input 1: control-store write strobe.
- `cfg_addr` input OPW+2: control-store write address.
- `cfg_data` input CW: control-store write data.
- `out_valid` output 1: `out_ctrl` is valid.
- `out_ctrl` output CW: registered control word.
- `out_last` output 1: final cycle of the current control word.
- `zflag` output 1: current zero-flag register.

## Operation

- Lookup address is `{in_mode, in_op, zflag}`. `zflag` is the register value before any same-edge update.
- Control-word bit meanings, [5:0]:
  - [5] reg_write
  - [4] mem_write
  - [3] branch_taken
  - [2] jump
  - [1] alu_to_reg
  - [0] mem_to_reg
- Opcode encoding, 0–15: CLR, ADD, SUB, AND, OR, LD, ST, SL, SR, SET, BZ, BNZ, INC, DEC, JMP, ADC.
- Reset contents for mode 1:
  - CLR, ADD, SUB, AND, OR, SL, SR, SET, INC, DEC, ADC: `100010`
  - LD: `100011`
  - ST: `010000`
  - JMP: `000100`
  - BZ: `00f000`, where f is the flag
  - BNZ: `00f'000`, where f' is the inverted flag
- Reset contents for mode 0: every entry is `10000` followed by op[OPW-1], independent of flag.
- Control-store write:
  - `cfg_we` writes `cfg_data` at the `CLK` edge.
  - A lookup in the same cycle to the same address returns the old contents.
  - The new value is visible from the next cycle.
- Zero flag: `flag_we` loads `alu_zero` into `zflag` at the edge.
- Accept happens when `in_valid && in_ready`. It registers the looked-up word into `out_ctrl` and sets `out_valid` for one cycle.
- Hold: if the accepted instruction has mode 1, op LD_OP or ST_OP, and `MEM_LAT > 0`:
  - a down-counter loads `MEM_LAT`;
  - `in_ready` goes low;
  - `out_ctrl` and `out_valid` hold until the counter reaches 0.
- `in_ready` = (counter == 0). It is combinational from state only, never from `in_valid`.
- `out_last` = `out_valid` && (counter == 0).
- With no accept and counter == 0, `out_valid` drops the next cycle. `out_ctrl` holds its last value.
- The block has no states beyond IDLE/ISSUE (counter == 0) and HOLD (counter > 0).

## Timing

- Reset values:
  - `out_valid` = 0, `out_ctrl` = 0, `out_last` = 0, `zflag` = 0.
  - Counter = 0, so `in_ready` = 1.
  - The control store is reloaded with the default table.
- Reset may assert mid-hold or mid-cfg write. All state clears immediately and any pending write is lost.
- Latency: accept at edge N gives `out_ctrl` valid after edge N (1 cycle).
- LD/ST occupancy is `1 + MEM_LAT` cycles of `out_valid`. `in_ready` is low for the `MEM_LAT` cycles following the accept.
- Back-to-back non-memory instructions sustain one accept per cycle with `out_valid` continuously high.
- `in_valid` asserted while `in_ready` = 0 is ignored. The source must hold it; the block does not buffer it.
- `flag_we` on the accept edge: the lookup uses the old flag, and the new flag applies to the next instruction.
- Counter wrap cannot occur: it only loads when 0 and saturates at 0.

## Test plan

- Reset, then accept ADD in mode 1 with zflag = 0 -> one cycle later `out_ctrl` = `100010`, `out_valid` = 1, `out_last` = 1, `in_ready` = 1.
- Set `zflag` = 1 via `flag_we`, then issue BZ and BNZ back-to-back -> `out_ctrl` = `001000` then `000000` on consecutive cycles.
- MEM_LAT = 3, issue LD then ADD held on `in_valid` -> `100011` valid for 4 cycles, `out_last` only on the 4th, `in_ready` low for 3 cycles, ADD accepted on the 4th cycle.
- Write `cfg_addr` = `{1, JMP, 0}` with data `111111` while JMP looks up the same address in the same cycle -> first result `000100`, next JMP returns `111111`. Then assert reset -> JMP returns `000100` again.
- Mode 0, op = 8 -> `100001`; op = 3 -> `100000`.
- Assert reset 2 cycles into an ST hold -> `out_valid` = 0 and `in_ready` = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_lut_seq.sv
// Registered control-word lookup for the SNACKS datapath: writable control store,
// zero-flag register and an LD/ST hold counter that back-pressures fetch.
module ctrl_lut_seq #(
   parameter int OPW     = 4,
   parameter int CW      = 6,
   parameter int MEM_LAT = 1,
   parameter int LD_OP   = 5,
   parameter int ST_OP   = 6
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_mode,
   input  logic [OPW-1:0]  in_op,
   input  logic            flag_we,
   input  logic            alu_zero,
   input  logic            cfg_we,
   input  logic [OPW+1:0]  cfg_addr,
   input  logic [CW-1:0]   cfg_data,
   output logic            out_valid,
   output logic [CW-1:0]   out_ctrl,
   output logic            out_last,
   output logic            zflag
);

   localparam int AW    = OPW + 2;
   localparam int DEPTH = 2 ** AW;

   localparam logic [3:0]     LAT    = 4'(MEM_LAT);
   localparam logic [OPW-1:0] LD_OPC = OPW'(LD_OP);
   localparam logic [OPW-1:0] ST_OPC = OPW'(ST_OP);
   localparam logic [OPW-1:0] OP_BZ  = OPW'(10);
   localparam logic [OPW-1:0] OP_BNZ = OPW'(11);
   localparam logic [OPW-1:0] OP_JMP = OPW'(14);

   // Legacy table: mode 0 decodes only the opcode MSB; BZ/BNZ fold the flag into branch_taken.
   function automatic logic [CW-1:0] default_word(input logic [AW-1:0] addr);
      logic [OPW-1:0] op;
      logic [5:0]     w;
      op = addr[OPW:1];
      w  = 6'b000000;
      if (!addr[AW-1]) begin
         w = {5'b10000, op[OPW-1]};
      end else if (op == LD_OPC) begin
         w = 6'b100011;
      end else if (op == ST_OPC) begin
         w = 6'b010000;
      end else begin
         case (op)
            OP_JMP:  w = 6'b000100;
            OP_BZ:   w = {2'b00, addr[0], 3'b000};
            OP_BNZ:  w = {2'b00, ~addr[0], 3'b000};
            default: w = 6'b100010;
         endcase
      end
      return CW'(w);
   endfunction

   logic [CW-1:0]  store_q [DEPTH];
   logic [CW-1:0]  store_d [DEPTH];
   logic [3:0]     cnt_q, cnt_d;
   logic           out_valid_q, out_valid_d;
   logic [CW-1:0]  out_ctrl_q, out_ctrl_d;
   logic           zflag_q, zflag_d;
   logic [AW-1:0]  lookup_addr_s;
   logic           accept_s;
   logic           is_mem_s;

   assign in_ready  = (cnt_q == 4'd0);
   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_last  = out_valid_q && (cnt_q == 4'd0);
   assign zflag     = zflag_q;

   // Next-state: lookup reads the pre-edge store and flag, so same-cycle writes are not forwarded.
   always_comb begin
      lookup_addr_s = {in_mode, in_op, zflag_q};
      accept_s      = in_valid && (cnt_q == 4'd0);
      is_mem_s      = in_mode && ((in_op == LD_OPC) || (in_op == ST_OPC));
      cnt_d         = cnt_q;
      out_valid_d   = 1'b0;
      out_ctrl_d    = out_ctrl_q;
      store_d       = store_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = store_q[lookup_addr_s];
         if (is_mem_s && (LAT != 4'd0)) begin
            cnt_d = LAT;
         end else begin
            cnt_d = 4'd0;
         end
      end else if (cnt_q != 4'd0) begin
         out_valid_d = 1'b1;
         cnt_d       = cnt_q - 4'd1;
      end else begin
         out_valid_d = 1'b0;
         cnt_d       = 4'd0;
      end
      if (flag_we) begin
         zflag_d = alu_zero;
      end else begin
         zflag_d = zflag_q;
      end
      if (cfg_we) begin
         store_d[cfg_addr] = cfg_data;
      end else begin
         store_d = store_q;
      end
   end

   // State registers; reset reloads the legacy table and drops any pending write.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            store_q[i] <= default_word(AW'(i));
         end
         cnt_q       <= 4'd0;
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         zflag_q     <= 1'b0;
      end else begin
         store_q     <= store_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         zflag_q     <= zflag_d;
      end
   end

endmodule

// File: tb/tb_ctrl_lut_seq.sv
// Scoreboard bench for ctrl_lut_seq: the driver predicts each output cycle from a
// table-level model and a monitor checks every cycle in which out_valid is high.
module tb_ctrl_lut_seq;

   localparam int LAT = 3;

   logic       CLK = 1'b0;
   logic       reset;
   logic       in_valid, in_ready, in_mode;
   logic [3:0] in_op;
   logic       flag_we, alu_zero, cfg_we;
   logic [5:0] cfg_addr, cfg_data;
   logic       out_valid, out_last, zflag;
   logic [5:0] out_ctrl;

   int total = 0;
   int bad   = 0;

   logic [5:0] store_m [64];
   int         zf_m;
   int         hold_m;
   logic [6:0] exp_q [$];

   ctrl_lut_seq #(.OPW(4), .CW(6), .MEM_LAT(LAT), .LD_OP(5), .ST_OP(6)) dut (
      .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_op(in_op), .flag_we(flag_we), .alu_zero(alu_zero),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .out_valid(out_valid), .out_ctrl(out_ctrl), .out_last(out_last), .zflag(zflag)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reset table derived directly from the opcode list (CLR..ADC = 0..15).
   function automatic logic [5:0] legacy_word(input int a);
      int mode, op, f;
      mode = (a >> 5) & 1;
      op   = (a >> 1) & 15;
      f    = a & 1;
      if (mode == 0) return (op >= 8) ? 6'b100001 : 6'b100000;
      case (op)
         5:       return 6'b100011;
         6:       return 6'b010000;
         14:      return 6'b000100;
         10:      return (f == 1) ? 6'b001000 : 6'b000000;
         11:      return (f == 1) ? 6'b000000 : 6'b001000;
         default: return 6'b100010;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) store_m[i] = legacy_word(i);
      zf_m   = 0;
      hold_m = 0;
      exp_q.delete();
   endtask

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic cyc(input logic v, input logic m, input logic [3:0] op,
                      input logic fwe, input logic az,
                      input logic cwe, input logic [5:0] ca, input logic [5:0] cd);
      int n;
      logic [5:0] w;
      in_valid = v; in_mode = m; in_op = op;
      flag_we = fwe; alu_zero = az;
      cfg_we = cwe; cfg_addr = ca; cfg_data = cd;
      chk("in_ready", in_ready, (hold_m == 0) ? 1 : 0);
      chk("zflag", zflag, zf_m);
      if (v && hold_m == 0) begin
         w = store_m[{m, op, (zf_m == 1)}];
         n = (m && (op == 4'd5 || op == 4'd6)) ? LAT + 1 : 1;
         for (int k = 0; k < n; k++) exp_q.push_back({w, (k == n - 1)});
         hold_m = n - 1;
      end else if (hold_m > 0) begin
         hold_m--;
      end
      if (cwe) store_m[ca] = cd;
      if (fwe) zf_m = az ? 1 : 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
   endtask

   task automatic issue(input logic m, input logic [3:0] op);
      cyc(1'b1, m, op, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; cfg_we = 1'b0; flag_we = 1'b0;
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every valid output cycle must match the oldest outstanding expectation.
   initial begin
      logic [6:0] e;
      forever begin
         @(negedge CLK);
         if (!reset) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_valid", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_ctrl", out_ctrl, e[6:1]);
                  chk("out_last", out_last, e[0]);
               end
            end else begin
               chk("out_last_idle", out_last, 1'b0);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_mode = 1'b0; in_op = 4'd0;
      flag_we = 1'b0; alu_zero = 1'b0; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_data = 6'd0;
      model_reset();
      @(posedge CLK);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_ctrl", out_ctrl, 6'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_zflag", zflag, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      reset = 1'b0;

      issue(1'b1, 4'd1);
      idle(1);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      issue(1'b1, 4'd10);
      issue(1'b1, 4'd11);
      idle(1);
      issue(1'b1, 4'd5);
      for (int i = 0; i < 5; i++) issue(1'b1, 4'd1);
      idle(1);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
      cyc(1'b1, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1, {1'b1, 4'd14, 1'b0}, 6'b111111);
      issue(1'b1, 4'd14);
      idle(1);
      do_reset();
      issue(1'b1, 4'd14);
      issue(1'b0, 4'd8);
      issue(1'b0, 4'd3);
      idle(1);

      issue(1'b1, 4'd6);
      idle(2);
      #2;
      reset = 1'b1;
      #1;
      chk("midhold_out_valid", out_valid, 1'b0);
      chk("midhold_in_ready", in_ready, 1'b1);
      chk("midhold_out_ctrl", out_ctrl, 6'd0);
      model_reset();
      @(posedge CLK);
      #1;
      reset = 1'b0;
      idle(1);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom),
             ($urandom_range(0, 7) == 0), 6'($urandom), 6'($urandom));
      end
      idle(LAT + 3);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
